// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the 8N1 UART receiver: frame constants and FSM state encoding.
`timescale 1ns/1ps
package uart_rx_core_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_DIV_MIN   = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core_fifo.sv
// Synchronous receive FIFO; pointers carry one extra wrap bit to tell full from empty.
`timescale 1ns/1ps
module uart_rx_core_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] dout_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    // When full, a same-cycle pop frees the head slot, which is exactly where the write lands.
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= din_i;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, sticky error flags, receive FIFO.
`timescale 1ns/1ps
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [DIV_W-1:0] clk_div,
    input  logic             rx_i,
    output logic [7:0]       rx_data_o,
    output logic             rx_valid_o,
    input  logic             rx_ready_i,
    output logic             busy_o,
    output logic             frame_err_o,
    output logic             overrun_o,
    input  logic             clear_err_i
);
    // state    | meaning
    // IDLE     | waiting for a falling edge on the synced line
    // START    | half-bit wait, confirm start bit still low
    // DATA     | sampling 8 data bits LSB first, one per bit period
    // STOP     | waiting for the stop-bit sample
    // BREAK    | line stuck low after a framing error, wait for high

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    rx_state_e         state_q;
    logic              sync1_q;
    logic              sync2_q;
    logic [DIV_W-1:0]  cnt_q;
    logic [DIV_W-1:0]  div_q;
    logic [2:0]        idx_q;
    logic [7:0]        shreg_q;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;

    logic [DIV_W-1:0]  div_eff;
    logic              expired;
    logic              push;
    logic              pop;
    logic              frame_evt;
    logic              overrun_evt;
    logic              fifo_full;
    logic              fifo_empty;

    assign div_eff     = (clk_div < DIV_W'(UART_DIV_MIN)) ? DIV_W'(UART_DIV_MIN) : clk_div;
    assign expired     = (cnt_q == DIV_W'(1));
    assign push        = (state_q == ST_STOP) && expired && sync2_q;
    assign frame_evt   = (state_q == ST_STOP) && expired && !sync2_q;
    assign pop         = rx_valid_o & rx_ready_i;
    assign overrun_evt = push & fifo_full & ~pop;

    assign rx_valid_o  = ~fifo_empty;
    assign busy_o      = (state_q != ST_IDLE);
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_W'(UART_DIV_MIN);
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!sync2_q) begin
                        state_q <= ST_START;
                        div_q   <= div_eff;
                        cnt_q   <= div_eff >> 1;
                    end
                end
                ST_START: begin
                    if (expired) begin
                        if (sync2_q) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_DATA;
                            idx_q   <= '0;
                            cnt_q   <= div_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (expired) begin
                        shreg_q[idx_q] <= sync2_q;
                        cnt_q          <= div_q;
                        if (idx_q == LAST_BIT) begin
                            state_q <= ST_STOP;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop gives half a bit of slack for a back-to-back start edge.
                    if (expired) begin
                        state_q <= sync2_q ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (sync2_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (clear_err_i) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (frame_evt) begin
            frame_err_d = 1'b1;
        end
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_core_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (shreg_q),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .dout_o  (rx_data_o)
    );

endmodule
